// File: rtl/load_store_unit.sv
// Load/store unit: decodes one load or store request at a time, performs
// byte/halfword extraction and read-modify-write merging against a word-wide
// RAM port, and serves a memory-mapped hardware counter without touching RAM.

`ifndef HARDWARE_COUNTER_ADDR
`define HARDWARE_COUNTER_ADDR 32'h0001_FFF0
`endif

module load_store_unit #(
    parameter logic [31:0] HC_ADDR = `HARDWARE_COUNTER_ADDR,
    parameter int          MEM_AW  = 15
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_store,
    input  logic [2:0]        req_load,
    input  logic [4:0]        req_rd,
    input  logic [31:0]       hc_data,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_data,
    output logic [4:0]        resp_rd,
    output logic              resp_err
);

    localparam logic [1:0] ST_SB   = 2'b00;
    localparam logic [1:0] ST_SH   = 2'b01;
    localparam logic [1:0] ST_SW   = 2'b10;
    localparam logic [1:0] ST_NONE = 2'b11;

    localparam logic [2:0] LD_LB   = 3'b000;
    localparam logic [2:0] LD_LH   = 3'b001;
    localparam logic [2:0] LD_LW   = 3'b010;
    localparam logic [2:0] LD_LBU  = 3'b011;
    localparam logic [2:0] LD_LHU  = 3'b100;
    localparam logic [2:0] LD_NONE = 3'b111;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        MERGE = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_t;

    // Returns 1 for opcode combinations and alignments the unit refuses.
    function automatic logic is_illegal(input logic [1:0] st, input logic [2:0] ld,
                                        input logic [1:0] lane);
        logic bad;
        if ((st != ST_NONE) && (ld != LD_NONE)) begin
            bad = 1'b1;
        end else if ((ld == 3'b101) || (ld == 3'b110)) begin
            bad = 1'b1;
        end else if (((ld == LD_LH) || (ld == LD_LHU) || (st == ST_SH)) && (lane == 2'b11)) begin
            bad = 1'b1;
        end else if (((ld == LD_LW) || (st == ST_SW)) && (lane != 2'b00)) begin
            bad = 1'b1;
        end else begin
            bad = 1'b0;
        end
        return bad;
    endfunction

    // Pulls the addressed byte/halfword/word out of a RAM word and extends it.
    function automatic logic [31:0] extract_load(input logic [2:0] ld, input logic [1:0] lane,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (ld)
            LD_LB:   r = {{24{b[7]}}, b};
            LD_LH:   r = {{16{h[15]}}, h};
            LD_LW:   r = word;
            LD_LBU:  r = {24'h00_0000, b};
            LD_LHU:  r = {16'h0000, h};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Replaces the addressed byte/halfword of a RAM word, keeping the rest.
    function automatic logic [31:0] merge_store(input logic [1:0] st, input logic [1:0] lane,
                                                input logic [31:0] word, input logic [31:0] wd);
        logic [31:0] r;
        r = word;
        case (st)
            ST_SB: r[{lane, 3'b000} +: 8] = wd[7:0];
            ST_SH: begin
                if (lane[1]) begin
                    r[31:16] = wd[15:0];
                end else begin
                    r[15:0] = wd[15:0];
                end
            end
            default: r = wd;
        endcase
        return r;
    endfunction

    state_t              state_r, state_next_s;
    logic [MEM_AW+1:0]   addr_r;
    logic [31:0]         wdata_r;
    logic [1:0]          store_r;
    logic [2:0]          load_r;
    logic [4:0]          rd_r;
    logic                mem_re_r, mem_we_r, resp_valid_r, resp_err_r;
    logic [31:0]         mem_wdata_r, resp_data_r;

    logic accept_s, illegal_s, noop_s, hc_load_s, hc_store_s, fast_resp_s;

    // Classify the incoming request so the IDLE transition can pick its path.
    always_comb begin
        accept_s    = (state_r == IDLE) && req_valid;
        illegal_s   = is_illegal(req_store, req_load, req_addr[1:0]);
        noop_s      = (req_store == ST_NONE) && (req_load == LD_NONE);
        hc_load_s   = !illegal_s && (req_store == ST_NONE) && (req_load == LD_LW)
                      && (req_addr == HC_ADDR);
        hc_store_s  = !illegal_s && (req_store != ST_NONE) && (req_addr == HC_ADDR);
        fast_resp_s = illegal_s || noop_s || hc_load_s || hc_store_s;
    end

    // Next-state selection for the request sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    if (fast_resp_s) begin
                        state_next_s = RESP;
                    end else if (req_store == ST_SW) begin
                        state_next_s = WRITE;
                    end else begin
                        state_next_s = READ;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            READ:  state_next_s = MERGE;
            MERGE: begin
                if (store_r != ST_NONE) begin
                    state_next_s = WRITE;
                end else begin
                    state_next_s = RESP;
                end
            end
            WRITE: state_next_s = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State, strobe and response registers; strobes are decoded from the
    // next state so they appear as clean one-cycle registered pulses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= IDLE;
            addr_r       <= '0;
            wdata_r      <= 32'h0000_0000;
            store_r      <= 2'b00;
            load_r       <= 3'b000;
            rd_r         <= 5'd0;
            mem_re_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_wdata_r  <= 32'h0000_0000;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_data_r  <= 32'h0000_0000;
        end else begin
            state_r      <= state_next_s;
            mem_re_r     <= (state_next_s == READ);
            mem_we_r     <= (state_next_s == WRITE);
            resp_valid_r <= (state_next_s == RESP);
            if (accept_s) begin
                addr_r      <= req_addr[MEM_AW+1:0];
                wdata_r     <= req_wdata;
                store_r     <= req_store;
                load_r      <= req_load;
                rd_r        <= req_rd;
                resp_err_r  <= illegal_s;
                resp_data_r <= hc_load_s ? hc_data : 32'h0000_0000;
                if ((req_store == ST_SW) && !fast_resp_s) begin
                    mem_wdata_r <= req_wdata;
                end
            end else if (state_r == MERGE) begin
                if (store_r != ST_NONE) begin
                    mem_wdata_r <= merge_store(store_r, addr_r[1:0], mem_rdata, wdata_r);
                end else begin
                    resp_data_r <= extract_load(load_r, addr_r[1:0], mem_rdata);
                end
            end else if ((state_r == RESP) && resp_ready) begin
                resp_data_r <= 32'h0000_0000;
                resp_err_r  <= 1'b0;
            end
        end
    end

    assign req_ready  = (state_r == IDLE) && !RST;
    assign mem_addr   = addr_r[MEM_AW+1:2];
    assign mem_re     = mem_re_r;
    assign mem_we     = mem_we_r;
    assign mem_wdata  = mem_wdata_r;
    assign resp_valid = resp_valid_r;
    assign resp_data  = resp_data_r;
    assign resp_rd    = rd_r;
    assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural one-cycle-latency RAM.
module tb_load_store_unit;

    localparam logic [31:0] HC = 32'h0001_FFF0;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [1:0]  req_store = 2'b11;
    logic [2:0]  req_load = 3'b111;
    logic [4:0]  req_rd = 5'd0;
    logic [31:0] hc_data = 32'h0000_BEEF;
    logic [14:0] mem_addr;
    logic        mem_re;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_err;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [4:0]  rd_tag = 5'd1;
    logic        ram_init = 1'b1;
    logic [31:0] ram [0:32767];

    load_store_unit #(.HC_ADDR(HC), .MEM_AW(15)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_store(req_store), .req_load(req_load), .req_rd(req_rd),
        .hc_data(hc_data),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_wdata(mem_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_rd(resp_rd), .resp_err(resp_err)
    );

    always #5 CLK = ~CLK;

    // RAM model: read data appears the cycle after mem_re, writes are full-word.
    always @(posedge CLK) begin
        if (ram_init) begin
            ram[15'h100] <= 32'h8899_AABB;
            ram[15'h002] <= 32'h0000_0000;
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            if (mem_re) mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request, observe it to completion and compare against the
    // expected strobe/response cycles (counted from the accept edge).
    task automatic run_req(input string tag, input logic [1:0] st, input logic [2:0] ld,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int hold, input logic rel_valid,
                           input int e_re, input int e_we, input int e_resp,
                           input logic [31:0] e_data, input logic e_err,
                           input logic [31:0] e_wdata);
        int cyc, re_cyc, we_cyc, re_n, we_n, resp_cyc, held;
        logic [31:0] r_data, w_data;
        logic [14:0] w_addr;
        logic        r_err, both, leak, unstable, rdy_bad, done;
        logic [4:0]  r_rd, my_rd;
        cyc = 0; re_cyc = 0; we_cyc = 0; re_n = 0; we_n = 0; resp_cyc = 0; held = 0;
        r_data = 32'h0; w_data = 32'h0; w_addr = 15'h0; r_err = 1'b0; r_rd = 5'd0;
        both = 1'b0; leak = 1'b0; unstable = 1'b0; rdy_bad = 1'b0; done = 1'b0;
        @(negedge CLK);
        check({tag, "_ready"}, {31'h0, req_ready}, 32'd1);
        my_rd = rd_tag;
        rd_tag = rd_tag + 5'd1;
        req_valid = 1'b1; req_store = st; req_load = ld; req_addr = addr;
        req_wdata = wdata; req_rd = my_rd;
        @(posedge CLK);
        while (!done && cyc < 40) begin
            @(negedge CLK);
            cyc++;
            if (cyc == 1) req_valid = 1'b0;
            if (mem_re) begin re_n++; re_cyc = cyc; end
            if (mem_we) begin we_n++; we_cyc = cyc; w_data = mem_wdata; w_addr = mem_addr; end
            if (mem_re && mem_we) both = 1'b1;
            if (!resp_valid) begin
                if (resp_data != 32'h0 || resp_err != 1'b0) leak = 1'b1;
            end else begin
                if (resp_cyc == 0) begin
                    resp_cyc = cyc; r_data = resp_data; r_err = resp_err; r_rd = resp_rd;
                end else if (resp_data !== r_data || resp_err !== r_err || resp_rd !== r_rd) begin
                    unstable = 1'b1;
                end
                if (req_ready) rdy_bad = 1'b1;
                if (held >= hold) begin
                    resp_ready = 1'b1;
                    if (rel_valid) begin
                        req_valid = 1'b1; req_store = 2'b11; req_load = 3'b111;
                    end
                    @(posedge CLK);
                    @(negedge CLK);
                    check({tag, "_released"}, {31'h0, resp_valid}, 32'd0);
                    check({tag, "_idle_after"}, {31'h0, req_ready}, 32'd1);
                    resp_ready = 1'b0;
                    req_valid = 1'b0;
                    done = 1'b1;
                end else begin
                    held++;
                end
            end
        end
        check({tag, "_completed"}, {31'h0, done}, 32'd1);
        check({tag, "_re_count"}, re_n, (e_re != 0) ? 32'd1 : 32'd0);
        check({tag, "_re_cycle"}, re_cyc, e_re);
        check({tag, "_we_count"}, we_n, (e_we != 0) ? 32'd1 : 32'd0);
        check({tag, "_we_cycle"}, we_cyc, e_we);
        check({tag, "_resp_cycle"}, resp_cyc, e_resp);
        check({tag, "_data"}, r_data, e_data);
        check({tag, "_err"}, {31'h0, r_err}, {31'h0, e_err});
        check({tag, "_rd"}, {27'h0, r_rd}, {27'h0, my_rd});
        check({tag, "_both_strobes"}, {31'h0, both}, 32'd0);
        check({tag, "_outside_resp_zero"}, {31'h0, leak}, 32'd0);
        check({tag, "_resp_stable"}, {31'h0, unstable}, 32'd0);
        check({tag, "_ready_in_resp"}, {31'h0, rdy_bad}, 32'd0);
        if (e_we != 0) begin
            check({tag, "_wdata"}, w_data, e_wdata);
            check({tag, "_waddr"}, {17'h0, w_addr}, {17'h0, addr[16:2]});
        end
    endtask

    initial begin : main
        logic we_seen;
        // reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        ram_init = 1'b0;
        check("rst_req_ready", {31'h0, req_ready}, 32'd0);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
        check("rst_mem_re", {31'h0, mem_re}, 32'd0);
        check("rst_mem_we", {31'h0, mem_we}, 32'd0);
        check("rst_resp_err", {31'h0, resp_err}, 32'd0);
        check("rst_resp_data", resp_data, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_addr", {17'h0, mem_addr}, 32'h0);
        RST = 1'b0;

        // loads from word 0x100 = 0x8899AABB
        run_req("lb_402",  2'b11, 3'b000, 32'h402, 32'h0, 0, 1'b0, 1, 0, 3, 32'hFFFF_FF99, 1'b0, 32'h0);
        run_req("lbu_402", 2'b11, 3'b011, 32'h402, 32'h0, 0, 1'b0, 1, 0, 3, 32'h0000_0099, 1'b0, 32'h0);
        // halfword store read-modify-write
        run_req("sh_402",  2'b01, 3'b111, 32'h402, 32'h1234, 0, 1'b0, 1, 3, 4, 32'h0, 1'b0, 32'h1234_AABB);
        run_req("lw_400",  2'b11, 3'b010, 32'h400, 32'h0, 0, 1'b0, 1, 0, 3, 32'h1234_AABB, 1'b0, 32'h0);
        run_req("lh_402",  2'b11, 3'b001, 32'h402, 32'h0, 0, 1'b0, 1, 0, 3, 32'h0000_1234, 1'b0, 32'h0);
        run_req("lhu_400", 2'b11, 3'b100, 32'h400, 32'h0, 0, 1'b0, 1, 0, 3, 32'h0000_AABB, 1'b0, 32'h0);
        run_req("lh_400",  2'b11, 3'b001, 32'h400, 32'h0, 0, 1'b0, 1, 0, 3, 32'hFFFF_AABB, 1'b0, 32'h0);
        run_req("lb_403",  2'b11, 3'b000, 32'h403, 32'h0, 0, 1'b0, 1, 0, 3, 32'h0000_0012, 1'b0, 32'h0);
        run_req("lb_401",  2'b11, 3'b000, 32'h401, 32'h0, 0, 1'b0, 1, 0, 3, 32'hFFFF_FFAA, 1'b0, 32'h0);
        // illegal requests
        run_req("lw_401",  2'b11, 3'b010, 32'h401, 32'h0, 0, 1'b0, 0, 0, 1, 32'h0, 1'b1, 32'h0);
        run_req("lh_403",  2'b11, 3'b001, 32'h403, 32'h0, 0, 1'b0, 0, 0, 1, 32'h0, 1'b1, 32'h0);
        run_req("ld_101",  2'b11, 3'b101, 32'h400, 32'h0, 0, 1'b0, 0, 0, 1, 32'h0, 1'b1, 32'h0);
        run_req("sb_lb",   2'b00, 3'b000, 32'h400, 32'h0, 0, 1'b0, 0, 0, 1, 32'h0, 1'b1, 32'h0);
        run_req("sw_402",  2'b10, 3'b111, 32'h402, 32'h0, 0, 1'b0, 0, 0, 1, 32'h0, 1'b1, 32'h0);
        // no-op and hardware counter
        run_req("noop",    2'b11, 3'b111, 32'h400, 32'h0, 0, 1'b0, 0, 0, 1, 32'h0, 1'b0, 32'h0);
        run_req("hc_lw",   2'b11, 3'b010, HC, 32'h0, 0, 1'b0, 0, 0, 1, 32'h0000_BEEF, 1'b0, 32'h0);
        run_req("hc_sw",   2'b10, 3'b111, HC, 32'h1111_1111, 0, 1'b0, 0, 0, 1, 32'h0, 1'b0, 32'h0);
        run_req("hc_sb",   2'b00, 3'b111, HC, 32'h22, 0, 1'b0, 0, 0, 1, 32'h0, 1'b0, 32'h0);
        // word store with back-pressure, request held valid at release
        run_req("sw_8",    2'b10, 3'b111, 32'h8, 32'hDEAD_BEEF, 5, 1'b1, 0, 1, 2, 32'h0, 1'b0, 32'hDEAD_BEEF);
        run_req("sb_8",    2'b00, 3'b111, 32'h8, 32'hA5A5_A577, 0, 1'b0, 1, 3, 4, 32'h0, 1'b0, 32'hDEAD_BE77);
        run_req("sb_b",    2'b00, 3'b111, 32'hB, 32'h11, 0, 1'b0, 1, 3, 4, 32'h0, 1'b0, 32'h11AD_BE77);
        run_req("lw_8",    2'b11, 3'b010, 32'h8, 32'h0, 0, 1'b0, 1, 0, 3, 32'h11AD_BE77, 1'b0, 32'h0);
        run_req("sh_a",    2'b01, 3'b111, 32'hA, 32'hCAFE, 0, 1'b0, 1, 3, 4, 32'h0, 1'b0, 32'hCAFE_BE77);
        run_req("lhu_a",   2'b11, 3'b100, 32'hA, 32'h0, 0, 1'b0, 1, 0, 3, 32'h0000_CAFE, 1'b0, 32'h0);
        run_req("lb_9",    2'b11, 3'b000, 32'h9, 32'h0, 0, 1'b0, 1, 0, 3, 32'hFFFF_FFBE, 1'b0, 32'h0);

        // reset during MERGE of a byte store must drop the write
        @(negedge CLK);
        req_valid = 1'b1; req_store = 2'b00; req_load = 3'b111;
        req_addr = 32'h400; req_wdata = 32'h55; req_rd = 5'd9;
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
        check("abort_read", {31'h0, mem_re}, 32'd1);
        @(negedge CLK);
        RST = 1'b1;
        we_seen = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("abort_resp_valid", {31'h0, resp_valid}, 32'd0);
        check("abort_mem_re", {31'h0, mem_re}, 32'd0);
        check("abort_mem_we", {31'h0, mem_we}, 32'd0);
        check("abort_resp_err", {31'h0, resp_err}, 32'd0);
        check("abort_resp_data", resp_data, 32'h0);
        check("abort_mem_wdata", mem_wdata, 32'h0);
        check("abort_mem_addr", {17'h0, mem_addr}, 32'h0);
        check("abort_ready_in_rst", {31'h0, req_ready}, 32'd0);
        RST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (mem_we) we_seen = 1'b1;
        end
        check("abort_no_write", {31'h0, we_seen}, 32'd0);
        check("abort_ram_kept", ram[15'h100], 32'h1234_AABB);
        check("abort_idle", {31'h0, req_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters SHALL be, one per line:
  HC_ADDR, `HARDWARE_COUNTER_ADDR, byte address of the memory-mapped hardware counter
  MEM_AW, 15, word-address width of the data RAM port
REQ-002 Ports SHALL be, one per line:
  CLK  in  1  single clock; all state updates on posedge
  RST  in  1  reset, synchronous, active-high
  req_valid  in  1  pipeline request valid
  req_ready  out  1  unit can accept a request
  req_addr  in  32  byte address
  req_wdata  in  32  store data (low bits used for SB/SH)
  req_store  in  2  00 SB, 01 SH, 10 SW, 11 none
  req_load  in  3  000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 111 none
  req_rd  in  5  destination register tag, returned unchanged
  hc_data  in  32  hardware counter value
  mem_addr  out  MEM_AW  RAM word address = addr[16:2]
  mem_re  out  1  RAM read strobe; mem_rdata valid the following cycle
  mem_rdata  in  32  RAM read data
  mem_we  out  1  RAM write strobe (full word)
  mem_wdata  out  32  RAM write word
  resp_valid  out  1  response valid
  resp_ready  in  1  consumer accepts response
  resp_data  out  32  load result (0 for stores/errors)
  resp_rd  out  5  tag of the request
  resp_err  out  1  misaligned or illegal request

Function
REQ-003 FSM states SHALL be IDLE, READ, MERGE, WRITE, RESP; req_ready SHALL be 1 only in IDLE and RST=0.
REQ-004 Accept occurs on a posedge with state IDLE and req_valid=1; addr, wdata, store, load, rd SHALL be registered then; mem_addr SHALL be driven from the registered addr until the next accept.
REQ-005 Illegal SHALL be: store!=11 and load!=111 together; load in 101/110; LH/LHU/SH with addr[1:0]=11; LW/SW with addr[1:0]!=00. Illegal -> RESP, resp_err=1, resp_data=0, no mem_re/mem_we.
REQ-006 No-op (store=11, load=111) SHALL go IDLE -> RESP with resp_err=0, resp_data=0.
REQ-007 LW with addr==HC_ADDR SHALL go IDLE -> RESP with resp_data=hc_data sampled at accept, no RAM access; any store to HC_ADDR SHALL be dropped (RESP, err=0, no mem_we).
REQ-008 Load: IDLE -> READ (mem_re=1, one cycle) -> MERGE (extract from mem_rdata, register resp_data) -> RESP; resp_valid first high 3 cycles after accept.
REQ-009 Extraction: byte lane = addr[1:0], halfword lane = addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word.
REQ-010 SW: IDLE -> WRITE (mem_we=1, mem_wdata=wdata) -> RESP; resp_valid 2 cycles after accept.
REQ-011 SB/SH: IDLE -> READ -> MERGE (replace addressed byte/halfword of mem_rdata with wdata[7:0]/[15:0], other bytes preserved) -> WRITE -> RESP; resp_valid 4 cycles after accept.
REQ-012 mem_re and mem_we SHALL be one-cycle pulses, never both 1.
REQ-013 RESP: resp_valid=1 and resp_data/resp_rd/resp_err stable until posedge with resp_ready=1, then IDLE; a new request SHALL NOT be accepted in that same cycle.
REQ-014 resp_data and resp_err SHALL be 0 outside RESP.

Reset
REQ-015 RST=1 at a posedge SHALL force IDLE; resp_valid, mem_re, mem_we, resp_err=0; resp_data, mem_wdata, registered request=0; req_ready=0 while RST=1.
REQ-016 RST asserted mid-operation SHALL abort: no mem_we in any cycle after the reset edge; a partially merged store SHALL never be written.

Verification
REQ-017 RAM word 0x100 = 0x8899AABB; LB addr 0x402 -> mem_re 1 cycle after accept, resp_data=0xFFFFFF99 3 cycles after accept; LBU same -> 0x00000099.
REQ-018 Same word; SH addr 0x402 wdata 0x1234 -> READ, then mem_we with mem_wdata=0x1234AABB at mem_addr 0x100, resp 4 cycles after accept, resp_err=0.
REQ-019 LW addr 0x401 -> resp_err=1, resp_data=0, no strobes, resp 1 cycle after accept; LH addr 0x403 -> resp_err=1.
REQ-020 LW addr=HC_ADDR, hc_data=0x0000BEEF -> resp_data=0x0000BEEF, no mem_re; SW to HC_ADDR -> no mem_we.
REQ-021 SW addr 0x8, wdata 0xDEADBEEF, resp_ready held 0 for 5 cycles -> mem_we once, resp_valid held, resp_data=0, req_ready=0 until release.
REQ-022 SB accepted, RST=1 during MERGE -> no mem_we ever, next cycle IDLE, all outputs 0.
